punc_control: RTL and testbench

//  Multi-cycle FSM controller for the PUnC LC3 core; drives every control input of PUnCDatapath, receives ir.

---
 rtl/punc_control_pkg.sv | 98 +++++++++
 rtl/punc_ctrl_decode.sv | 46 ++++
 rtl/punc_control.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_punc_control.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/punc_control_pkg.sv
// Shared definitions for the PUnC LC3 controller: opcode codes, mux select
// codes, ALU function codes, SEXT one-hots, FSM states, instruction classes
// and the registered control-word bundle.
package punc_control_pkg;

   // Opcode field values (ir[15:12])
   localparam logic [3:0] OC_BR   = 4'b0000;
   localparam logic [3:0] OC_ADD  = 4'b0001;
   localparam logic [3:0] OC_LD   = 4'b0010;
   localparam logic [3:0] OC_ST   = 4'b0011;
   localparam logic [3:0] OC_JSR  = 4'b0100;
   localparam logic [3:0] OC_AND  = 4'b0101;
   localparam logic [3:0] OC_LDR  = 4'b0110;
   localparam logic [3:0] OC_STR  = 4'b0111;
   localparam logic [3:0] OC_RSV8 = 4'b1000;
   localparam logic [3:0] OC_NOT  = 4'b1001;
   localparam logic [3:0] OC_LDI  = 4'b1010;
   localparam logic [3:0] OC_STI  = 4'b1011;
   localparam logic [3:0] OC_JMP  = 4'b1100;
   localparam logic [3:0] OC_RSVD = 4'b1101;
   localparam logic [3:0] OC_LEA  = 4'b1110;
   localparam logic [3:0] OC_HALT = 4'b1111;

   // Memory read address mux
   localparam logic [2:0] MUX_SELECT_MEM_PC       = 3'd0;
   localparam logic [2:0] MUX_SELECT_MEM_PC_ADDER = 3'd1;
   localparam logic [2:0] MUX_SELECT_MEM_INDIRECT = 3'd2;
   localparam logic [2:0] MUX_SELECT_MEM_R_DATA   = 3'd3;
   localparam logic [2:0] MUX_SELECT_MEM_ALU_C    = 3'd4;

   // Register file write data mux
   localparam logic [1:0] MUX_SELECT_RF_ALU_C    = 2'd0;
   localparam logic [1:0] MUX_SELECT_RF_PC       = 2'd1;
   localparam logic [1:0] MUX_SELECT_RF_MEM      = 2'd2;
   localparam logic [1:0] MUX_SELECT_RF_PC_ADDER = 2'd3;

   // ALU functions
   localparam logic [1:0] ALU_FN_PASS = 2'd0;
   localparam logic [1:0] ALU_FN_ADD  = 2'd1;
   localparam logic [1:0] ALU_FN_AND  = 2'd2;
   localparam logic [1:0] ALU_FN_NOT  = 2'd3;

   // Sign-extension source one-hots
   localparam logic [3:0] SEXT_IMM5  = 4'b1000;
   localparam logic [3:0] SEXT_OFF6  = 4'b0100;
   localparam logic [3:0] SEXT_OFF9  = 4'b0010;
   localparam logic [3:0] SEXT_OFF11 = 4'b0001;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_FETCH,
      ST_DECODE,
      ST_EXECUTE,
      ST_EXEC2,
      ST_SETCC,
      ST_HALT
   } state_t;

   typedef enum logic [3:0] {
      CL_ADD, CL_AND, CL_NOT, CL_BR, CL_JMP, CL_JSR, CL_LD, CL_LDR,
      CL_LEA, CL_LDI, CL_STI, CL_ST, CL_STR, CL_HALT, CL_RSVD
   } instr_class_t;

   // Every registered control output of the controller
   typedef struct packed {
      logic       mem_wr_en;
      logic [2:0] mem_r_addr_sel;
      logic       state2_sti;
      logic       str;
      logic [2:0] rf_wr_addr;
      logic       rf_wr_en;
      logic [2:0] rf_r_addr_0;
      logic [2:0] rf_r_addr_1;
      logic [1:0] rf_w_data_sel;
      logic       ir_ld;
      logic       jmp_ret_jsrr;
      logic       pc_ld;
      logic       pc_clr;
      logic       pc_up;
      logic       add_const;
      logic [1:0] alu_sel;
      logic       cc_en;
      logic       n;
      logic       z;
      logic       p;
      logic [3:0] sext_select;
      logic       halted;
   } ctl_t;

   // Control word held while in INIT: only the PC clear is active
   function automatic ctl_t init_ctl();
      ctl_t w;
      w        = '0;
      w.pc_clr = 1'b1;
      return w;
   endfunction

endpackage

// File: rtl/punc_ctrl_decode.sv
// Combinational instruction decode for the PUnC controller: classifies the
// instruction register and slices out the register/immediate fields.
module punc_ctrl_decode
   import punc_control_pkg::*;
(
   input  logic [15:0]  ir,
   output instr_class_t cls,
   output logic [2:0]   dr,
   output logic [2:0]   sr1,
   output logic [2:0]   sr2,
   output logic         imm,
   output logic         jsr_long,
   output logic [10:0]  const_field
);

   assign dr          = ir[11:9];
   assign sr1         = ir[8:6];
   assign sr2         = ir[2:0];
   assign imm         = ir[5];
   assign jsr_long    = ir[11];
   assign const_field = ir[10:0];

   // Map the opcode onto an instruction class; reserved codes fall to CL_RSVD
   always_comb begin
      cls = CL_RSVD;
      case (ir[15:12])
         OC_BR:   cls = CL_BR;
         OC_ADD:  cls = CL_ADD;
         OC_LD:   cls = CL_LD;
         OC_ST:   cls = CL_ST;
         OC_JSR:  cls = CL_JSR;
         OC_AND:  cls = CL_AND;
         OC_LDR:  cls = CL_LDR;
         OC_STR:  cls = CL_STR;
         OC_NOT:  cls = CL_NOT;
         OC_LDI:  cls = CL_LDI;
         OC_STI:  cls = CL_STI;
         OC_JMP:  cls = CL_JMP;
         OC_LEA:  cls = CL_LEA;
         OC_HALT: cls = CL_HALT;
         OC_RSV8, OC_RSVD: cls = CL_RSVD;
         default: cls = CL_RSVD;
      endcase
   end

endmodule

// File: rtl/punc_control.sv
// Multi-cycle FSM controller for the PUnC LC3 core. Every control output is
// registered and computed from the state being entered plus the decoded IR.
// Optional feature: define PUNC_ILLEGAL_OP_EN to make reserved opcodes
// (1000/1101) halt the core and raise a sticky illegal_op output; otherwise
// they behave as 3-cycle NOPs and illegal_op does not exist.
// The ir[10:0] passthrough is named ir_const because const is a reserved word.
module punc_control
   import punc_control_pkg::*;
#(
   parameter int CNT_W = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      ir,
   output logic             mem_wr_en,
   output logic [2:0]       mem_r_addr_sel,
   output logic             state2_STI,
   output logic             STR,
   output logic [2:0]       RF_wr_addr,
   output logic             RF_wr_en,
   output logic [2:0]       RF_r_addr_0,
   output logic [2:0]       RF_r_addr_1,
   output logic [1:0]       RF_w_data_sel,
   output logic             ir_ld,
   output logic             JMP_RET_JSRR,
   output logic             pc_ld,
   output logic             pc_clr,
   output logic             pc_up,
   output logic             add_const,
   output logic [1:0]       alu_sel,
   output logic             cc_en,
   output logic             n,
   output logic             z,
   output logic             p,
   output logic [10:0]      ir_const,
   output logic [3:0]       SEXT_Select,
   output logic             halted,
   output logic [CNT_W-1:0] instr_cnt
`ifdef PUNC_ILLEGAL_OP_EN
   ,
   output logic             illegal_op
`endif
);

   state_t       state;
   state_t       nxt_state;
   ctl_t         ctl_q;
   ctl_t         nxt_ctl;
   logic         retire;
   instr_class_t cls;
   logic [2:0]   dr;
   logic [2:0]   sr1;
   logic [2:0]   sr2;
   logic         imm;
   logic         jsr_long;
`ifdef PUNC_ILLEGAL_OP_EN
   logic         ill_set;
`endif

   punc_ctrl_decode u_decode (
      .ir          (ir),
      .cls         (cls),
      .dr          (dr),
      .sr1         (sr1),
      .sr2         (sr2),
      .imm         (imm),
      .jsr_long    (jsr_long),
      .const_field (ir_const)
   );

   // Choose the next state and build the control word that state will present
   always_comb begin
      nxt_state = state;
      nxt_ctl   = '0;
      retire    = 1'b0;
`ifdef PUNC_ILLEGAL_OP_EN
      ill_set   = 1'b0;
`endif

      case (state)
         ST_INIT:   nxt_state = ST_FETCH;
         ST_FETCH:  nxt_state = ST_DECODE;
         ST_DECODE: nxt_state = ST_EXECUTE;
         ST_EXECUTE: begin
            case (cls)
               CL_LD, CL_LDR, CL_LEA: nxt_state = ST_SETCC;
               CL_LDI, CL_STI:        nxt_state = ST_EXEC2;
               CL_HALT: begin
                  nxt_state = ST_HALT;
                  retire    = 1'b1;
               end
               CL_RSVD: begin
`ifdef PUNC_ILLEGAL_OP_EN
                  nxt_state = ST_HALT;
                  ill_set   = 1'b1;
`else
                  nxt_state = ST_FETCH;
`endif
                  retire    = 1'b1;
               end
               default: begin
                  nxt_state = ST_FETCH;
                  retire    = 1'b1;
               end
            endcase
         end
         ST_EXEC2: begin
            if (cls == CL_LDI) begin
               nxt_state = ST_SETCC;
            end else begin
               nxt_state = ST_FETCH;
               retire    = 1'b1;
            end
         end
         ST_SETCC: begin
            nxt_state = ST_FETCH;
            retire    = 1'b1;
         end
         ST_HALT:  nxt_state = ST_HALT;
         default:  nxt_state = ST_INIT;
      endcase

      case (nxt_state)
         ST_INIT: nxt_ctl = init_ctl();
         ST_FETCH: begin
            nxt_ctl.mem_r_addr_sel = MUX_SELECT_MEM_PC;
            nxt_ctl.ir_ld          = 1'b1;
            nxt_ctl.pc_up          = 1'b1;
         end
         ST_EXECUTE: begin
            case (cls)
               CL_ADD, CL_AND: begin
                  nxt_ctl.rf_r_addr_0   = sr1;
                  nxt_ctl.rf_r_addr_1   = sr2;
                  nxt_ctl.add_const     = imm;
                  nxt_ctl.sext_select   = SEXT_IMM5;
                  nxt_ctl.alu_sel       = (cls == CL_ADD) ? ALU_FN_ADD : ALU_FN_AND;
                  nxt_ctl.rf_wr_addr    = dr;
                  nxt_ctl.rf_wr_en      = 1'b1;
                  nxt_ctl.rf_w_data_sel = MUX_SELECT_RF_ALU_C;
                  nxt_ctl.cc_en         = 1'b1;
               end
               CL_NOT: begin
                  nxt_ctl.rf_r_addr_0   = sr1;
                  nxt_ctl.alu_sel       = ALU_FN_NOT;
                  nxt_ctl.rf_wr_addr    = dr;
                  nxt_ctl.rf_wr_en      = 1'b1;
                  nxt_ctl.rf_w_data_sel = MUX_SELECT_RF_ALU_C;
                  nxt_ctl.cc_en         = 1'b1;
               end
               CL_BR: begin
                  nxt_ctl.sext_select = SEXT_OFF9;
                  {nxt_ctl.n, nxt_ctl.z, nxt_ctl.p} = dr;
               end
               CL_JMP: begin
                  nxt_ctl.rf_r_addr_0  = sr1;
                  nxt_ctl.alu_sel      = ALU_FN_PASS;
                  nxt_ctl.jmp_ret_jsrr = 1'b1;
                  nxt_ctl.pc_ld        = 1'b1;
               end
               CL_JSR: begin
                  nxt_ctl.rf_wr_addr    = 3'd7;
                  nxt_ctl.rf_wr_en      = 1'b1;
                  nxt_ctl.rf_w_data_sel = MUX_SELECT_RF_PC;
                  nxt_ctl.pc_ld         = 1'b1;
                  if (jsr_long) begin
                     nxt_ctl.sext_select = SEXT_OFF11;
                  end else begin
                     nxt_ctl.rf_r_addr_0  = sr1;
                     nxt_ctl.alu_sel      = ALU_FN_PASS;
                     nxt_ctl.jmp_ret_jsrr = 1'b1;
                  end
               end
               CL_LD: begin
                  nxt_ctl.sext_select    = SEXT_OFF9;
                  nxt_ctl.mem_r_addr_sel = MUX_SELECT_MEM_PC_ADDER;
                  nxt_ctl.rf_wr_addr     = dr;
                  nxt_ctl.rf_wr_en       = 1'b1;
                  nxt_ctl.rf_w_data_sel  = MUX_SELECT_RF_MEM;
               end
               CL_LDR: begin
                  nxt_ctl.rf_r_addr_0    = sr1;
                  nxt_ctl.alu_sel        = ALU_FN_ADD;
                  nxt_ctl.add_const      = 1'b1;
                  nxt_ctl.sext_select    = SEXT_OFF6;
                  nxt_ctl.mem_r_addr_sel = MUX_SELECT_MEM_ALU_C;
                  nxt_ctl.rf_wr_addr     = dr;
                  nxt_ctl.rf_wr_en       = 1'b1;
                  nxt_ctl.rf_w_data_sel  = MUX_SELECT_RF_MEM;
               end
               CL_LEA: begin
                  nxt_ctl.sext_select   = SEXT_OFF9;
                  nxt_ctl.rf_wr_addr    = dr;
                  nxt_ctl.rf_wr_en      = 1'b1;
                  nxt_ctl.rf_w_data_sel = MUX_SELECT_RF_PC_ADDER;
               end
               CL_LDI, CL_STI: begin
                  nxt_ctl.sext_select    = SEXT_OFF9;
                  nxt_ctl.mem_r_addr_sel = MUX_SELECT_MEM_PC_ADDER;
               end
               CL_ST: begin
                  nxt_ctl.rf_r_addr_0 = dr;
                  nxt_ctl.alu_sel     = ALU_FN_PASS;
                  nxt_ctl.sext_select = SEXT_OFF9;
                  nxt_ctl.mem_wr_en   = 1'b1;
               end
               CL_STR: begin
                  nxt_ctl.rf_r_addr_0 = sr1;
                  nxt_ctl.rf_r_addr_1 = dr;
                  nxt_ctl.alu_sel     = ALU_FN_ADD;
                  nxt_ctl.add_const   = 1'b1;
                  nxt_ctl.sext_select = SEXT_OFF6;
                  nxt_ctl.str         = 1'b1;
                  nxt_ctl.mem_wr_en   = 1'b1;
               end
               default: nxt_ctl = '0;
            endcase
         end
         ST_EXEC2: begin
            if (cls == CL_LDI) begin
               nxt_ctl.mem_r_addr_sel = MUX_SELECT_MEM_INDIRECT;
               nxt_ctl.rf_wr_addr     = dr;
               nxt_ctl.rf_wr_en       = 1'b1;
               nxt_ctl.rf_w_data_sel  = MUX_SELECT_RF_MEM;
            end else begin
               nxt_ctl.state2_sti  = 1'b1;
               nxt_ctl.str         = 1'b1;
               nxt_ctl.rf_r_addr_1 = dr;
               nxt_ctl.mem_wr_en   = 1'b1;
            end
         end
         ST_SETCC: begin
            nxt_ctl.rf_r_addr_0 = dr;
            nxt_ctl.alu_sel     = ALU_FN_PASS;
            nxt_ctl.cc_en       = 1'b1;
         end
         ST_HALT: nxt_ctl.halted = 1'b1;
         default: nxt_ctl = '0;
      endcase
   end

   // State, registered control word and retired-instruction counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_INIT;
         ctl_q     <= init_ctl();
         instr_cnt <= '0;
`ifdef PUNC_ILLEGAL_OP_EN
         illegal_op <= 1'b0;
`endif
      end else begin
         state <= nxt_state;
         ctl_q <= nxt_ctl;
         if (retire) begin
            instr_cnt <= instr_cnt + CNT_W'(1);
         end
`ifdef PUNC_ILLEGAL_OP_EN
         if (ill_set) begin
            illegal_op <= 1'b1;
         end
`endif
      end
   end

   assign mem_wr_en      = ctl_q.mem_wr_en;
   assign mem_r_addr_sel = ctl_q.mem_r_addr_sel;
   assign state2_STI     = ctl_q.state2_sti;
   assign STR            = ctl_q.str;
   assign RF_wr_addr     = ctl_q.rf_wr_addr;
   assign RF_wr_en       = ctl_q.rf_wr_en;
   assign RF_r_addr_0    = ctl_q.rf_r_addr_0;
   assign RF_r_addr_1    = ctl_q.rf_r_addr_1;
   assign RF_w_data_sel  = ctl_q.rf_w_data_sel;
   assign ir_ld          = ctl_q.ir_ld;
   assign JMP_RET_JSRR   = ctl_q.jmp_ret_jsrr;
   assign pc_ld          = ctl_q.pc_ld;
   assign pc_clr         = ctl_q.pc_clr;
   assign pc_up          = ctl_q.pc_up;
   assign add_const      = ctl_q.add_const;
   assign alu_sel        = ctl_q.alu_sel;
   assign cc_en          = ctl_q.cc_en;
   assign n              = ctl_q.n;
   assign z              = ctl_q.z;
   assign p              = ctl_q.p;
   assign SEXT_Select    = ctl_q.sext_select;
   assign halted         = ctl_q.halted;

endmodule

// File: tb/tb_punc_control.sv
// Self-checking bench for punc_control. The bench plays the datapath's IR:
// it presents each instruction once the controller has issued its fetch, and
// compares every cycle's control outputs with a per-instruction model.
module tb_punc_control;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic [15:0]      ir;
   logic             mem_wr_en;
   logic [2:0]       mem_r_addr_sel;
   logic             state2_STI;
   logic             STR;
   logic [2:0]       RF_wr_addr;
   logic             RF_wr_en;
   logic [2:0]       RF_r_addr_0;
   logic [2:0]       RF_r_addr_1;
   logic [1:0]       RF_w_data_sel;
   logic             ir_ld;
   logic             JMP_RET_JSRR;
   logic             pc_ld;
   logic             pc_clr;
   logic             pc_up;
   logic             add_const;
   logic [1:0]       alu_sel;
   logic             cc_en;
   logic             n;
   logic             z;
   logic             p;
   logic [10:0]      ir_const;
   logic [3:0]       SEXT_Select;
   logic             halted;
   logic [CNT_W-1:0] instr_cnt;
`ifdef PUNC_ILLEGAL_OP_EN
   logic             illegal_op;
`endif

   punc_control #(.CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .ir             (ir),
      .mem_wr_en      (mem_wr_en),
      .mem_r_addr_sel (mem_r_addr_sel),
      .state2_STI     (state2_STI),
      .STR            (STR),
      .RF_wr_addr     (RF_wr_addr),
      .RF_wr_en       (RF_wr_en),
      .RF_r_addr_0    (RF_r_addr_0),
      .RF_r_addr_1    (RF_r_addr_1),
      .RF_w_data_sel  (RF_w_data_sel),
      .ir_ld          (ir_ld),
      .JMP_RET_JSRR   (JMP_RET_JSRR),
      .pc_ld          (pc_ld),
      .pc_clr         (pc_clr),
      .pc_up          (pc_up),
      .add_const      (add_const),
      .alu_sel        (alu_sel),
      .cc_en          (cc_en),
      .n              (n),
      .z              (z),
      .p              (p),
      .ir_const       (ir_const),
      .SEXT_Select    (SEXT_Select),
      .halted         (halted),
      .instr_cnt      (instr_cnt)
`ifdef PUNC_ILLEGAL_OP_EN
      ,
      .illegal_op     (illegal_op)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       mem_wr_en;
      logic [2:0] mem_sel;
      logic       sti2;
      logic       str;
      logic [2:0] wr_addr;
      logic       wr_en;
      logic [2:0] r0;
      logic [2:0] r1;
      logic [1:0] wsel;
      logic       ir_ld;
      logic       jmp;
      logic       pc_ld;
      logic       pc_clr;
      logic       pc_up;
      logic       addc;
      logic [1:0] alu;
      logic       cc_en;
      logic       n;
      logic       z;
      logic       p;
      logic [3:0] sext;
      logic       halted;
   } ctl_t;

   typedef struct {
      logic [15:0] instr;
      int          cycles;
      logic [3:0]  sext;
      logic [2:0]  mem_sel;
      logic        rf_wr;
   } vec_t;

   ctl_t act;
   assign act = {mem_wr_en, mem_r_addr_sel, state2_STI, STR, RF_wr_addr, RF_wr_en,
                 RF_r_addr_0, RF_r_addr_1, RF_w_data_sel, ir_ld, JMP_RET_JSRR,
                 pc_ld, pc_clr, pc_up, add_const, alu_sel, cc_en, n, z, p,
                 SEXT_Select, halted};

   int checks   = 0;
   int failures = 0;
   int exp_cnt  = 0;

   // Cycle count of an instruction, straight from the latency table
   function automatic int model_len(input logic [15:0] i);
      case (i[15:12])
         4'b0010, 4'b0110, 4'b1110, 4'b1011: return 4;
         4'b1010:                            return 5;
         default:                            return 3;
      endcase
   endfunction

   // Control word expected in cycle 'phase' of instruction i (0 = fetch cycle)
   function automatic ctl_t model_word(input logic [15:0] i, input int phase);
      ctl_t       w;
      logic [3:0] op;
      logic [2:0] dr;
      logic [2:0] b;
      w  = '0;
      op = i[15:12];
      dr = i[11:9];
      b  = i[8:6];
      if (phase == 0) begin
         w.ir_ld = 1'b1;
         w.pc_up = 1'b1;
      end else if (phase == 2) begin
         case (op)
            4'b0001, 4'b0101: begin
               w.r0 = b; w.r1 = i[2:0]; w.addc = i[5]; w.sext = 4'b1000;
               w.alu = (op == 4'b0001) ? 2'd1 : 2'd2;
               w.wr_addr = dr; w.wr_en = 1'b1; w.cc_en = 1'b1;
            end
            4'b1001: begin
               w.r0 = b; w.alu = 2'd3; w.wr_addr = dr; w.wr_en = 1'b1; w.cc_en = 1'b1;
            end
            4'b0000: begin
               w.sext = 4'b0010; {w.n, w.z, w.p} = dr;
            end
            4'b1100: begin
               w.r0 = b; w.jmp = 1'b1; w.pc_ld = 1'b1;
            end
            4'b0100: begin
               w.wr_addr = 3'd7; w.wr_en = 1'b1; w.wsel = 2'd1; w.pc_ld = 1'b1;
               if (i[11]) w.sext = 4'b0001;
               else begin w.r0 = b; w.jmp = 1'b1; end
            end
            4'b0010: begin
               w.sext = 4'b0010; w.mem_sel = 3'd1; w.wr_addr = dr; w.wr_en = 1'b1; w.wsel = 2'd2;
            end
            4'b0110: begin
               w.r0 = b; w.alu = 2'd1; w.addc = 1'b1; w.sext = 4'b0100; w.mem_sel = 3'd4;
               w.wr_addr = dr; w.wr_en = 1'b1; w.wsel = 2'd2;
            end
            4'b1110: begin
               w.sext = 4'b0010; w.wr_addr = dr; w.wr_en = 1'b1; w.wsel = 2'd3;
            end
            4'b1010, 4'b1011: begin
               w.sext = 4'b0010; w.mem_sel = 3'd1;
            end
            4'b0011: begin
               w.r0 = dr; w.sext = 4'b0010; w.mem_wr_en = 1'b1;
            end
            4'b0111: begin
               w.r0 = b; w.r1 = dr; w.alu = 2'd1; w.addc = 1'b1; w.sext = 4'b0100;
               w.str = 1'b1; w.mem_wr_en = 1'b1;
            end
            default: w = '0;
         endcase
      end else if (phase == 3) begin
         if (op == 4'b1010) begin
            w.mem_sel = 3'd2; w.wr_addr = dr; w.wr_en = 1'b1; w.wsel = 2'd2;
         end else if (op == 4'b1011) begin
            w.sti2 = 1'b1; w.str = 1'b1; w.r1 = dr; w.mem_wr_en = 1'b1;
         end else if (op == 4'b0010 || op == 4'b0110 || op == 4'b1110) begin
            w.r0 = dr; w.cc_en = 1'b1;
         end
      end else if (phase == 4 && op == 4'b1010) begin
         w.r0 = dr; w.cc_en = 1'b1;
      end
      return w;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Run one instruction from its fetch cycle until the next fetch appears
   task automatic applyStimulus(input logic [15:0] instr, output int cycles, output ctl_t exec_w);
      bit done;
      done   = 1'b0;
      cycles = 0;
      exec_w = '0;
      while (!done && cycles < 8) begin
         checkOutput($sformatf("op %h cycle %0d", instr, cycles), act, model_word(instr, cycles));
         if (cycles == 2) exec_w = act;
         if (cycles == 0) begin
            checkOutput("instr_cnt", instr_cnt, 64'(exp_cnt % 65536));
            ir = instr;
            #1;
            checkOutput("ir_const", ir_const, instr[10:0]);
         end
         @(posedge clk);
         @(negedge clk);
         cycles++;
         if (act.ir_ld) done = 1'b1;
      end
      if (!done) begin
         checks++;
         failures++;
         $display("[TB] FAIL op %h no refetch: got none within %0d cycles required %0d", instr, cycles, model_len(instr));
      end
      exp_cnt++;
   endtask

   // Assert reset at a negedge, check INIT, release and land in FETCH
   task automatic doReset();
      ctl_t w;
      w = '0;
      w.pc_clr = 1'b1;
      rst = 1'b1;
      #1;
      checkOutput("reset word", act, w);
      checkOutput("reset instr_cnt", instr_cnt, 0);
`ifdef PUNC_ILLEGAL_OP_EN
      checkOutput("reset illegal_op", illegal_op, 0);
`endif
      exp_cnt = 0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Run an instruction that ends in HALT and watch it stay there
   task automatic runHalt(input logic [15:0] instr);
      ctl_t hw;
      hw = '0;
      hw.halted = 1'b1;
      checkOutput("halt fetch", act, model_word(instr, 0));
      ir = instr;
      for (int ph = 1; ph <= 2; ph++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput($sformatf("halt op %h cycle %0d", instr, ph), act, model_word(instr, ph));
      end
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput($sformatf("halt hold %0d", c), act, hw);
      end
      checkOutput("halt instr_cnt", instr_cnt, 64'(exp_cnt + 1));
`ifdef PUNC_ILLEGAL_OP_EN
      checkOutput("illegal_op", illegal_op, (instr[15:12] == 4'hF) ? 64'd0 : 64'd1);
`endif
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t        vecs[14];
      int          cyc;
      ctl_t        ew;
      logic [15:0] r;

      vecs[0]  = '{16'h1025, 3, 4'b1000, 3'd0, 1'b1};
      vecs[1]  = '{16'h5262, 3, 4'b1000, 3'd0, 1'b1};
      vecs[2]  = '{16'h0402, 3, 4'b0010, 3'd0, 1'b0};
      vecs[3]  = '{16'hA002, 5, 4'b0010, 3'd1, 1'b0};
      vecs[4]  = '{16'h76BF, 3, 4'b0100, 3'd0, 1'b0};
      vecs[5]  = '{16'hB602, 4, 4'b0010, 3'd1, 1'b0};
      vecs[6]  = '{16'h4804, 3, 4'b0001, 3'd0, 1'b1};
      vecs[7]  = '{16'hC1C0, 3, 4'b0000, 3'd0, 1'b0};
      vecs[8]  = '{16'h2203, 4, 4'b0010, 3'd1, 1'b1};
      vecs[9]  = '{16'h6283, 4, 4'b0100, 3'd4, 1'b1};
      vecs[10] = '{16'hE5FF, 4, 4'b0010, 3'd0, 1'b1};
      vecs[11] = '{16'h903F, 3, 4'b0000, 3'd0, 1'b1};
      vecs[12] = '{16'h4080, 3, 4'b0000, 3'd0, 1'b1};
      vecs[13] = '{16'h3403, 3, 4'b0010, 3'd0, 1'b0};

      rst = 1'b0;
      ir  = 16'h0000;
      #1;
      rst = 1'b1;
      #1;
      checkOutput("power-on pc_clr", pc_clr, 1);
      checkOutput("power-on instr_cnt", instr_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);

      $display("[TB] directed vector table");
      foreach (vecs[k]) begin
         applyStimulus(vecs[k].instr, cyc, ew);
         checkOutput($sformatf("latency %h", vecs[k].instr), cyc, vecs[k].cycles);
         checkOutput($sformatf("exec sext %h", vecs[k].instr), ew.sext, vecs[k].sext);
         checkOutput($sformatf("exec mem_sel %h", vecs[k].instr), ew.mem_sel, vecs[k].mem_sel);
         checkOutput($sformatf("exec rf_wr %h", vecs[k].instr), ew.wr_en, vecs[k].rf_wr);
      end

      $display("[TB] randomized instruction stream");
      for (int k = 0; k < 40; k++) begin
         r = 16'($urandom);
         if (r[15:12] == 4'hF) r[15:12] = 4'h1;
`ifdef PUNC_ILLEGAL_OP_EN
         if (r[15:12] == 4'h8 || r[15:12] == 4'hD) r[15:12] = 4'h5;
`endif
         applyStimulus(r, cyc, ew);
         checkOutput($sformatf("random latency %h", r), cyc, model_len(r));
      end

      $display("[TB] reset in the middle of LDI");
      checkOutput("ldi fetch", act, model_word(16'hA002, 0));
      ir = 16'hA002;
      for (int ph = 1; ph <= 3; ph++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput($sformatf("ldi cycle %0d", ph), act, model_word(16'hA002, ph));
      end
      doReset();

      $display("[TB] reserved opcode");
`ifdef PUNC_ILLEGAL_OP_EN
      runHalt(16'hD000);
      doReset();
`else
      applyStimulus(16'hD000, cyc, ew);
      checkOutput("reserved latency", cyc, 3);
      applyStimulus(16'h8000, cyc, ew);
      checkOutput("reserved8 latency", cyc, 3);
`endif

      $display("[TB] HALT");
      runHalt(16'hF025);
      doReset();
      checkOutput("post-halt fetch", act, model_word(16'h0000, 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
